xbus_arbiter: RTL

- Two-master round-robin arbiter sharing the single system data bus that feeds the address decoder.
- Master 0 is the controller core; master 1 is the external/DMA port.
- Grants are registered and muxed onto one bus: select, address, write enable and write data.
- Read data and acknowledge are routed back to the owning master.
- Supports a lock request, so one master can hold the bus for back-to-back accesses.

---
 rtl/xbus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter for the shared system data bus. The optional
// forced hand-over of a locked owner is built when XARB_TIMEOUT_EN is defined.
module xbus_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              gnt,
  input  logic              req,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              acc,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  assign acc   = gnt & req;
  assign ack   = acc;
  assign rdata = acc ? bus_rdata : '0;
endmodule

module xbus_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef XARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);
  localparam int NM = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state, state_n;
  logic   last;
  logic   own, oth;

  logic [NM-1:0]             req, lock, we, gnt, acc, ack;
  logic [NM-1:0][ADDR_W-1:0] addr;
  logic [NM-1:0][DATA_W-1:0] wdata, rdata;

  assign req   = {m1_req, m0_req};
  assign lock  = {m1_lock, m0_lock};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  assign gnt = {state == OWN1, state == OWN0};
  assign own = (state == OWN1);
  assign oth = ~own;

  genvar g;
  generate
    for (g = 0; g < NM; g++) begin : g_port
      xbus_arb_port #(.DATA_W(DATA_W)) u_port (
        .gnt(gnt[g]), .req(req[g]), .bus_rdata(bus_rdata),
        .acc(acc[g]), .ack(ack[g]), .rdata(rdata[g])
      );
    end
  endgenerate

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_ack   = ack[0];
  assign m1_ack   = ack[1];
  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];

  // At most one acc bit is ever set, so the loop collapses to a one-hot mux.
  always_comb begin
    bus_sel   = 1'b0;
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (acc[i]) begin
        bus_sel   = 1'b1;
        bus_addr  = addr[i];
        bus_we    = we[i];
        bus_wdata = wdata[i];
      end
    end
  end

`ifdef XARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       force_rel;
  assign force_rel = (state != IDLE) && req[own] && lock[own] && req[oth] &&
                     (hold_cnt == HOLD_MAX);
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (&req)        state_n = last ? OWN0 : OWN1;
        else if (req[0]) state_n = OWN0;
        else if (req[1]) state_n = OWN1;
      end
      OWN0, OWN1: begin
        if (req[own] && lock[own]) begin
`ifdef XARB_TIMEOUT_EN
          if (force_rel) state_n = oth ? OWN1 : OWN0;
`endif
        end else if (req[oth]) begin
          state_n = oth ? OWN1 : OWN0;
        end else if (!req[own]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      if (state_n != state && state_n != IDLE) last <= (state_n == OWN1);
    end
  end

`ifdef XARB_TIMEOUT_EN
  // Counter parks at HOLD_MAX so a late request from the other side is served at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_n != state)                           hold_cnt <= '0;
      else if (state != IDLE && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
      if (force_rel) timeout_err <= 1'b1;
    end
  end
`endif

endmodule
